// File: rtl/fp_result_packer.sv
// ============================================================================
// fp_result_packer
//
// Captures floating-point unit results into a small record FIFO and
// serializes each record as a stream of 32-bit words for a host:
//
//   HDR = {8'hA5, fmt[1:0], flags[4:0], P, seq[15:0]}
//   HI  = result[63:32]        (only when fmt != 0, i.e. double)
//   LO  = result[31:0]         (out_last = 1)
//
// Every in_valid cycle consumes a 16-bit sequence number, whether the record
// is stored or dropped, so the host can spot gaps in the stream. A record
// arriving while the FIFO is full, with no pop in the same cycle, is dropped;
// this sets the sticky overflow flag and bumps a saturating drop counter.
//
// Optional feature (macro FP_RESULT_PACKER_PARITY_EN):
//   defined   -> HDR bit P is the XOR of the 64 result bits and 5 flag bits,
//                computed when the record is pushed.
//   undefined -> P is tied to 0 and no parity logic exists.
//
// Output handshake: a word moves when out_valid and out_ready are both high
// on a rising clock edge. out_valid depends only on the serializer state, and
// out_data/out_last only on the state and the FIFO head, so while the host
// stalls (out_valid=1, out_ready=0) the presented word cannot change.
//
// Ports:
//   clock       single clock, rising edge
//   reset       asynchronous, active-low reset
//   in_valid    FP unit result strobe
//   in_result   64-bit FP result
//   in_flags    5-bit exception flags
//   in_fmt      2-bit format (0 = single, otherwise double)
//   in_clear    synchronous clear of overflow and drop_count
//   out_valid   out_data holds a valid word
//   out_ready   host accepts the word
//   out_data    32-bit stream word
//   out_last    final word of a record
//   overflow    sticky: at least one record was dropped
//   drop_count  number of dropped records, saturating at 16'hFFFF
//   dbg_state   serializer state (0 idle, 1 hdr, 2 hi, 3 lo)
//
// Parameter:
//   DEPTH       FIFO record capacity, power of two in 2..64
// ============================================================================
module fp_result_packer #(
    parameter int DEPTH = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [63:0] in_result,
    input  logic [4:0]  in_flags,
    input  logic [1:0]  in_fmt,
    input  logic        in_clear,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_last,
    output logic        overflow,
    output logic [15:0] drop_count,
    output logic [1:0]  dbg_state
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    // Encoding fixed so that dbg_state has a documented meaning.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_HI   = 2'd2,
        ST_LO   = 2'd3
    } state_t;

    typedef struct packed {
        logic [15:0] seq;
        logic [1:0]  fmt;
        logic [4:0]  flags;
        logic        par;
        logic [63:0] result;
    } rec_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t         state_q, state_d;
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [AW:0]    count_q, count_d;
    logic [15:0]    seq_q, seq_d;
    logic           overflow_q, overflow_d;
    logic [15:0]    drop_count_q, drop_count_d;

    rec_t           mem_q [DEPTH];

    // ------------------------------------------------------------------
    // Push / pop decisions
    // ------------------------------------------------------------------
    logic  full;
    logic  pop;
    logic  push;
    logic  drop;
    logic  push_par;
    rec_t  push_rec;
    rec_t  head;

`ifdef FP_RESULT_PACKER_PARITY_EN
    assign push_par = ^{in_result, in_flags};
`else
    assign push_par = 1'b0;
`endif

    assign full = (count_q == FULL_CNT);

    // The head record stays in the FIFO while it is being serialized and
    // leaves only on the LO handshake, so the FIFO occupancy always counts
    // the record currently on the wire.
    assign pop  = (state_q == ST_LO) && out_ready;

    // A full FIFO still accepts a record when the head leaves in the same
    // cycle; only a push that finds no free slot is dropped.
    assign push = in_valid && (!full || pop);
    assign drop = in_valid && full && !pop;

    assign push_rec = '{seq:    seq_q,
                        fmt:    in_fmt,
                        flags:  in_flags,
                        par:    push_par,
                        result: in_result};

    assign head = mem_q[rd_ptr_q];

    // ------------------------------------------------------------------
    // FIFO bookkeeping, sequence number and drop statistics
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        seq_d        = seq_q;
        overflow_d   = overflow_q;
        drop_count_d = drop_count_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        // The sequence number counts attempts, not stored records.
        if (in_valid) begin
            seq_d = seq_q + 16'd1;
        end

        // A drop wins over a simultaneous clear: the clear wipes the old
        // history and the new drop is then recorded as the first one.
        if (drop) begin
            overflow_d = 1'b1;
            if (in_clear) begin
                drop_count_d = 16'd1;
            end else if (drop_count_q != 16'hFFFF) begin
                drop_count_d = drop_count_q + 16'd1;
            end
        end else if (in_clear) begin
            overflow_d   = 1'b0;
            drop_count_d = 16'd0;
        end
    end

    // ------------------------------------------------------------------
    // Serializer FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            seq_q        <= '0;
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            seq_q        <= seq_d;
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
        end
    end

    // Record storage needs no reset: the pointers and count define which
    // entries are live, and a reset empties the FIFO by clearing them.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_rec;
        end
    end

    // ------------------------------------------------------------------
    // Serializer FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                // Looking at the incoming push as well as the count lets the
                // header appear one cycle after the strobe.
                if ((count_q != '0) || push) begin
                    state_d = ST_HDR;
                end
            end
            ST_HDR: begin
                if (out_ready) begin
                    state_d = (head.fmt != 2'd0) ? ST_HI : ST_LO;
                end
            end
            ST_HI: begin
                if (out_ready) begin
                    state_d = ST_LO;
                end
            end
            ST_LO: begin
                // count_d already includes this pop and any same-cycle push,
                // so back-to-back records flow without an idle cycle.
                if (out_ready) begin
                    state_d = (count_d != '0) ? ST_HDR : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Serializer FSM: output logic
    // ------------------------------------------------------------------
    always_comb begin
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_data  = 32'd0;
        unique case (state_q)
            ST_HDR: begin
                out_valid = 1'b1;
                out_data  = {8'hA5, head.fmt, head.flags, head.par, head.seq};
            end
            ST_HI: begin
                out_valid = 1'b1;
                out_data  = head.result[63:32];
            end
            ST_LO: begin
                out_valid = 1'b1;
                out_last  = 1'b1;
                out_data  = head.result[31:0];
            end
            default: begin
                out_valid = 1'b0;
            end
        endcase
    end

    assign overflow   = overflow_q;
    assign drop_count = drop_count_q;
    assign dbg_state  = state_q;

    // ------------------------------------------------------------------
    // Invariants
    // ------------------------------------------------------------------
    a_count_bound: assert property (
        @(posedge clock) disable iff (!reset)
        count_q <= FULL_CNT
    );

    a_hold_on_stall: assert property (
        @(posedge clock) disable iff (!reset)
        (out_valid && !out_ready) |=>
            (out_valid && $stable(out_data) && $stable(out_last))
    );

    a_busy_means_nonempty: assert property (
        @(posedge clock) disable iff (!reset)
        (state_q != ST_IDLE) |-> (count_q != '0)
    );

endmodule
